// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Arms a trigger, records a fixed-length burst into a storage FIFO, waits
//   for the FIFO to drain, then pulses the trigger comparator reset before
//   returning to IDLE or, with auto re-arm, to ARMED.
//
// Ports
//   clk_i             system clock, all logic on the rising edge
//   rst_i             synchronous active-high reset
//   arm_cmd_i         pulse: arm the trigger
//   disarm_cmd_i      pulse: disarm / cancel a pending auto re-arm
//   force_cmd_i       pulse: start a capture with no trigger
//   auto_rearm_i      level: re-arm after a capture completes
//   triggered_i       trigger comparator fired (synchronous level)
//   capture_len_i     samples per capture (0 is treated as 1)
//   fifo_not_full_i   storage FIFO can accept writes
//   fifo_empty_i      storage FIFO fully read out
//   record_strobe_o   FIFO write strobe
//   trigger_armed_o   arm enable to the trigger controller
//   trigger_reset_o   comparator reset pulse
//   capture_done_o    one-cycle pulse as the drain phase completes
//   overflow_o        sticky: capture cut short by a full FIFO
//   state_o           current state code
//
// state   | meaning
// IDLE    | waiting for arm or force
// ARMED   | trigger armed, waiting for trigger or force
// RECORD  | strobing samples into the FIFO
// DRAIN   | waiting for the FIFO to be read out
// TRIGRST | holding the comparator reset
module capture_sequencer #(
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_cmd_i,
  input  logic             disarm_cmd_i,
  input  logic             force_cmd_i,
  input  logic             auto_rearm_i,
  input  logic             triggered_i,
  input  logic [CNT_W-1:0] capture_len_i,
  input  logic             fifo_not_full_i,
  input  logic             fifo_empty_i,
  output logic             record_strobe_o,
  output logic             trigger_armed_o,
  output logic             trigger_reset_o,
  output logic             capture_done_o,
  output logic             overflow_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RECORD  = 3'd2,
    DRAIN   = 3'd3,
    TRIGRST = 3'd4
  } state_e;

  // One down-counter serves both the record length and the reset hold time.
  localparam logic [CNT_W-1:0] TRST_LOAD = (RST_CYC < 1) ? CNT_W'(1) : CNT_W'(RST_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rearm_q, rearm_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_eff;
  logic             cnt_last;

  assign len_eff  = (capture_len_i == '0) ? CNT_W'(1) : capture_len_i;
  assign cnt_last = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (force_cmd_i) begin
          state_d = RECORD;
          cnt_d   = len_eff;
          ovf_d   = 1'b0;
        end else if (arm_cmd_i) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (triggered_i || force_cmd_i) begin
          state_d = RECORD;
          cnt_d   = len_eff;
        end else if (disarm_cmd_i) begin
          state_d = IDLE;
        end
      end
      RECORD: begin
        // The counter holds at 1 on the final strobe, so it never wraps.
        if (!fifo_not_full_i) begin
          ovf_d   = 1'b1;
          state_d = DRAIN;
          rearm_d = 1'b1;
        end else if (cnt_last) begin
          state_d = DRAIN;
          rearm_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (disarm_cmd_i) rearm_d = 1'b0;
        if (fifo_empty_i) begin
          state_d = TRIGRST;
          cnt_d   = TRST_LOAD;
          done_d  = 1'b1;
        end
      end
      TRIGRST: begin
        if (disarm_cmd_i) rearm_d = 1'b0;
        if (cnt_last) begin
          state_d = (auto_rearm_i && rearm_q && !disarm_cmd_i) ? ARMED : IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rearm_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign record_strobe_o = (state_q == RECORD);
  assign trigger_armed_o = (state_q == ARMED);
  assign trigger_reset_o = (state_q == TRIGRST);
  assign capture_done_o  = done_q;
  assign overflow_o      = ovf_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
//   Directed vector table, hand-written multi-cycle scenarios and a random
//   run compared against a behavioural model of the capture sequencer.
module tb_capture_sequencer;

  localparam int CNT_W   = 16;
  localparam int RST_CYC = 4;

  logic             clk;
  logic             rst, arm, dis, frc, aut, trg, fnf, fe;
  logic [CNT_W-1:0] len;
  logic             strobe, armed, trst, done, ovf;
  logic [2:0]       st;

  int n_total = 0;
  int n_pass  = 0;

  capture_sequencer #(.CNT_W(CNT_W), .RST_CYC(RST_CYC)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .arm_cmd_i      (arm),
    .disarm_cmd_i   (dis),
    .force_cmd_i    (frc),
    .auto_rearm_i   (aut),
    .triggered_i    (trg),
    .capture_len_i  (len),
    .fifo_not_full_i(fnf),
    .fifo_empty_i   (fe),
    .record_strobe_o(strobe),
    .trigger_armed_o(armed),
    .trigger_reset_o(trst),
    .capture_done_o (done),
    .overflow_o     (ovf),
    .state_o        (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase name, samples taken so far vs. length, and
  // comparator-reset cycles elapsed vs. RST_CYC.
  int m_st = 0, m_len = 1, m_taken = 0, m_held = 0;
  bit m_rearm = 0, m_ov = 0, m_cd = 0;

  task automatic model_step();
    m_cd = 0;
    if (rst) begin
      m_st = 0; m_ov = 0; m_rearm = 0;
    end else begin
      case (m_st)
        0: if (frc) begin m_st = 2; m_taken = 0; m_len = (len == 0) ? 1 : int'(len); m_ov = 0; end
           else if (arm) begin m_st = 1; m_ov = 0; end
        1: if (trg || frc) begin m_st = 2; m_taken = 0; m_len = (len == 0) ? 1 : int'(len); end
           else if (dis) m_st = 0;
        2: begin
          m_taken++;
          if (!fnf) begin m_ov = 1; m_st = 3; m_rearm = 1; end
          else if (m_taken >= m_len) begin m_st = 3; m_rearm = 1; end
        end
        3: begin
          if (dis) m_rearm = 0;
          if (fe) begin m_st = 4; m_cd = 1; m_held = 0; end
        end
        4: begin
          if (dis) m_rearm = 0;
          m_held++;
          if (m_held >= RST_CYC) m_st = (aut && m_rearm) ? 1 : 0;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_state(input int code, input int lim, input string nm);
    int k = 0;
    while (int'(st) != code && k < lim) begin tick(); k++; end
    chk(nm, int'(st), code);
  endtask

  task automatic idle_inputs();
    rst = 0; arm = 0; dis = 0; frc = 0; trg = 0;
  endtask

  typedef struct packed {
    bit rst, arm, dis, frc, aut, trg;
    logic [15:0] len;
    bit fnf, fe;
    logic [2:0] e_st;
    bit e_stb, e_arm, e_trst, e_done, e_ov;
  } vec_t;

  vec_t vq[$];

  initial begin
    int n;
    int k;
    bit seen_done, bad_st;
    logic [7:0] act, exp;

    rst = 1; arm = 0; dis = 0; frc = 0; aut = 0; trg = 0; len = '0; fnf = 1; fe = 0;

    //            rst arm dis frc aut trg len fnf fe  st stb arm trst done ov
    vq.push_back('{1, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 0, 16'd0, 1, 1, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd3, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd4, 0, 0, 1, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 3'd0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 1, 0, 0, 16'd2, 1, 1, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd2, 1, 1, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd2, 1, 1, 3'd3, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 0, 0, 0, 0, 16'd2, 1, 1, 3'd0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 16'd2, 1, 1, 3'd1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 1, 16'd3, 1, 0, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 16'd9, 1, 0, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 1, 0, 0, 16'd9, 1, 0, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd9, 1, 0, 3'd3, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 16'd9, 1, 1, 3'd4, 0, 0, 1, 1, 0});
    vq.push_back('{0, 0, 0, 0, 1, 0, 16'd9, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 0, 16'd9, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 0, 16'd9, 1, 1, 3'd4, 0, 0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 0, 16'd9, 1, 1, 3'd0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 16'd9, 1, 1, 3'd1, 0, 1, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 16'd9, 1, 1, 3'd0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 0, 16'd5, 1, 0, 3'd2, 1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd5, 0, 0, 3'd3, 0, 0, 0, 0, 1});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd5, 1, 0, 3'd3, 0, 0, 0, 0, 1});
    vq.push_back('{0, 0, 0, 0, 0, 0, 16'd5, 1, 1, 3'd4, 0, 0, 1, 1, 1});

    foreach (vq[i]) begin
      rst = vq[i].rst; arm = vq[i].arm; dis = vq[i].dis; frc = vq[i].frc;
      aut = vq[i].aut; trg = vq[i].trg; len = vq[i].len; fnf = vq[i].fnf; fe = vq[i].fe;
      tick();
      act = {st, strobe, armed, trst, done, ovf};
      exp = {vq[i].e_st, vq[i].e_stb, vq[i].e_arm, vq[i].e_trst, vq[i].e_done, vq[i].e_ov};
      chk($sformatf("vec[%0d] {st,stb,arm,trst,done,ov}", i), int'(act), int'(exp));
    end

    // Armed capture, trigger 5 cycles after arm, length 8.
    idle_inputs(); aut = 0; fnf = 1; fe = 0; rst = 1; tick(); rst = 0;
    chk("reset state", int'({st, strobe, armed, trst, done, ovf}), 0);
    len = 16'd8; arm = 1; tick(); arm = 0;
    chk("len8 armed state", int'(st), 1);
    repeat (4) tick();
    trg = 1; tick(); trg = 0;
    chk("len8 first strobe", int'(strobe), 1);
    chk("len8 record state", int'(st), 2);
    n = 1; k = 0;
    while (strobe && k < 50) begin tick(); if (strobe) n++; k++; end
    chk("len8 strobe count", n, 8);
    chk("len8 drain state", int'(st), 3);
    fe = 1; tick();
    chk("len8 done pulse", int'(done), 1);
    wait_state(0, 20, "len8 back to idle");

    // Overflow at strobe cycle 40 of 100.
    fe = 0; len = 16'd100; frc = 1; tick(); frc = 0;
    n = int'(strobe); k = 0;
    while (n < 40 && k < 100) begin tick(); if (strobe) n++; k++; end
    fnf = 0; tick(); k = 0;
    while (strobe && k < 10) begin n++; tick(); k++; end
    fnf = 1;
    chk("ovf strobe count 40..41", int'(n == 40 || n == 41), 1);
    chk("ovf flag set", int'(ovf), 1);
    fe = 1;
    wait_state(0, 30, "ovf back to idle");
    chk("ovf sticky in idle", int'(ovf), 1);
    fe = 0; arm = 1; tick(); arm = 0;
    chk("ovf cleared by arm", int'(ovf), 0);
    chk("ovf arm state", int'(st), 1);

    // Auto re-arm, two triggers.
    rst = 1; tick(); rst = 0;
    aut = 1; len = 16'd5; fe = 1; arm = 1; tick(); arm = 0;
    trg = 1; tick(); trg = 0;
    wait_state(4, 20, "rearm reach trigrst");
    wait_state(1, 20, "rearm back to armed");
    chk("rearm trigger armed", int'(armed), 1);
    trg = 1; tick(); trg = 0;
    n = int'(strobe); k = 0;
    while (strobe && k < 50) begin tick(); if (strobe) n++; k++; end
    chk("rearm second length", n, 5);
    aut = 0;
    wait_state(0, 30, "rearm settle idle");

    // Reset at strobe cycle 3 of 8.
    fe = 0; len = 16'd8; frc = 1; tick(); frc = 0;
    tick(); tick();
    chk("mid-record strobe", int'(strobe), 1);
    rst = 1; tick(); rst = 0;
    chk("reset mid strobe", int'(strobe), 0);
    chk("reset mid state", int'(st), 0);
    fe = 1; seen_done = 0; bad_st = 0;
    repeat (6) begin tick(); seen_done |= done; bad_st |= (st != 3'd0); end
    chk("no done after reset", int'(seen_done), 0);
    chk("stays idle after reset", int'(bad_st), 0);

    // Random run against the model.
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      arm = ($urandom_range(0, 7) == 0);
      dis = ($urandom_range(0, 15) == 0);
      frc = ($urandom_range(0, 15) == 0);
      trg = ($urandom_range(0, 5) == 0);
      aut = ($urandom_range(0, 3) != 0);
      fnf = ($urandom_range(0, 19) != 0);
      fe  = ($urandom_range(0, 2) == 0);
      len = CNT_W'($urandom_range(0, 12));
      tick();
      act = {st, strobe, armed, trst, done, ovf};
      exp = {3'(m_st), (m_st == 2), (m_st == 1), (m_st == 4), m_cd, m_ov};
      chk($sformatf("random cycle %0d {st,stb,arm,trst,done,ov}", c), int'(act), int'(exp));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
